lc3_mem_arbiter: RTL and testbench



---
 rtl/lc3_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - two-requester arbiter for the shared LC-3 memory port with watchdog
module lc3_mem_arbiter #(
   parameter int RR_MODE = 1,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_en,
   input  logic [1:0]  req_we,
   input  logic [15:0] req_addr0,
   input  logic [15:0] req_addr1,
   input  logic [15:0] req_wdata0,
   input  logic [15:0] req_wdata1,
   output logic [1:0]  req_rdy,
   output logic [1:0]  req_err,
   output logic [15:0] req_rdata,
   output logic        gnt_id,
   output logic        memEN,
   output logic        memWE,
   output logic [15:0] memory_addr,
   output logic [15:0] memory_din,
   input  logic [15:0] memory_dout,
   input  logic        memRDY
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [15:0] TIMEOUT_W = TIMEOUT[15:0];

   state_t      state_q, state_d;
   logic        en_q, en_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] din_q, din_d;
   logic [1:0]  rdy_q, rdy_d;
   logic [1:0]  err_q, err_d;
   logic [15:0] rdata_q, rdata_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [15:0] wd_q, wd_d;
   logic        win;
   logic        timeout_hit;

   // Winner selection: a lone requester wins; on contention alternate or favour requester 0.
   always_comb begin
      win = 1'b0;
      if (req_en == 2'b11) begin
         win = (RR_MODE != 0) ? ~last_q : 1'b0;
      end else begin
         win = req_en[1];
      end
   end

   // Watchdog fires on the BUSY edge where the count has reached the limit; zero disables it.
   always_comb begin
      timeout_hit = (TIMEOUT_W != 16'd0) && (wd_q == TIMEOUT_W);
   end

   // Next-state and registered-output logic; completion flags default low so they pulse once.
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      we_d    = we_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdy_d   = 2'b00;
      err_d   = 2'b00;
      rdata_d = rdata_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wd_d    = wd_q;
      case (state_q)
         S_IDLE: begin
            if (|req_en) begin
               state_d = S_BUSY;
               en_d    = 1'b1;
               we_d    = req_we[win];
               addr_d  = win ? req_addr1 : req_addr0;
               din_d   = win ? req_wdata1 : req_wdata0;
               gnt_d   = win;
               last_d  = win;
               wd_d    = 16'd0;
            end
         end
         S_BUSY: begin
            if (memRDY) begin
               state_d        = S_DONE;
               en_d           = 1'b0;
               we_d           = 1'b0;
               rdata_d        = memory_dout;
               rdy_d[gnt_q]   = 1'b1;
            end else if (timeout_hit) begin
               state_d        = S_DONE;
               en_d           = 1'b0;
               we_d           = 1'b0;
               rdata_d        = 16'hDEAD;
               rdy_d[gnt_q]   = 1'b1;
               err_d[gnt_q]   = 1'b1;
            end else begin
               wd_d = wd_q + 16'd1;
            end
         end
         S_DONE: begin
            // The finishing requester still holds req_en here, so no new grant is made.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 16'd0;
         din_q   <= 16'd0;
         rdy_q   <= 2'b00;
         err_q   <= 2'b00;
         rdata_q <= 16'd0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         wd_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end

   assign req_rdy     = rdy_q;
   assign req_err     = err_q;
   assign req_rdata   = rdata_q;
   assign gnt_id      = gnt_q;
   assign memEN       = en_q;
   assign memWE       = we_q;
   assign memory_addr = addr_q;
   assign memory_din  = din_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - self-checking bench for lc3_mem_arbiter
module tb_lc3_mem_arbiter;

   localparam int TO = 10;

   logic        clk;
   logic        rst;
   logic [1:0]  req_en;
   logic [1:0]  req_we;
   logic [15:0] addr0, addr1, wd0, wd1;
   logic [15:0] mdout;
   logic        mrdy;

   logic [1:0]  rdy_a, err_a, rdy_b, err_b;
   logic [15:0] rdata_a, rdata_b;
   logic        gnt_a, gnt_b;
   logic        en_a, en_b, we_a, we_b;
   logic [15:0] maddr_a, maddr_b, mdin_a, mdin_b;

   logic [15:0] mem_model [0:255];
   int          m_last;
   int          last_gap;
   int          n_pass;
   int          n_checks;
   int          w;

   lc3_mem_arbiter #(.RR_MODE(1), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we),
      .req_addr0(addr0), .req_addr1(addr1), .req_wdata0(wd0), .req_wdata1(wd1),
      .req_rdy(rdy_a), .req_err(err_a), .req_rdata(rdata_a), .gnt_id(gnt_a),
      .memEN(en_a), .memWE(we_a), .memory_addr(maddr_a), .memory_din(mdin_a),
      .memory_dout(mdout), .memRDY(mrdy)
   );

   lc3_mem_arbiter #(.RR_MODE(0), .TIMEOUT(TO)) u_dut_fp (
      .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we),
      .req_addr0(addr0), .req_addr1(addr1), .req_wdata0(wd0), .req_wdata1(wd1),
      .req_rdy(rdy_b), .req_err(err_b), .req_rdata(rdata_b), .gnt_id(gnt_b),
      .memEN(en_b), .memWE(we_b), .memory_addr(maddr_b), .memory_din(mdin_b),
      .memory_dout(mdout), .memRDY(mrdy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_timeout got=running exp=finished");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int r);
      req_en[r] = 1'b1;
      req_we[r] = 1'($urandom_range(0, 1));
      if (r == 0) begin
         addr0 = 16'($urandom);
         wd0   = 16'($urandom);
      end else begin
         addr1 = 16'($urandom);
         wd1   = 16'($urandom);
      end
   endtask

   // One complete access; lat < 0 means memory never answers.
   task automatic do_access(input int lat, input bit chk_b, output int win);
      int          cnt;
      logic [15:0] ea, ed, exp_rd;
      logic        ewe;
      logic [1:0]  oh;
      cnt = 0;
      while (!en_a && cnt < 30) begin
         tick();
         cnt++;
      end
      last_gap = cnt;
      check_eq("grant_seen", 64'(en_a), 64'(1));
      if (req_en == 2'b11) win = (m_last == 0) ? 1 : 0;
      else win = req_en[1] ? 1 : 0;
      m_last = win;
      ea  = (win == 1) ? addr1 : addr0;
      ed  = (win == 1) ? wd1 : wd0;
      ewe = req_we[win];
      oh  = (win == 1) ? 2'b10 : 2'b01;
      exp_rd = mem_model[ea[7:0]];
      check_eq("gnt", 64'(gnt_a), 64'(win));
      check_eq("grant_bus", 64'({we_a, maddr_a, mdin_a}), 64'({ewe, ea, ed}));
      if (lat < 0) begin
         for (int i = 1; i <= TO + 1; i++) begin
            tick();
            if (i <= TO) begin
               check_eq("to_wait", 64'({en_a, rdy_a}), 64'({1'b1, 2'b00}));
            end else begin
               check_eq("to_rdy", 64'(rdy_a), 64'(oh));
               check_eq("to_err", 64'(err_a), 64'(oh));
               check_eq("to_rdata", 64'(rdata_a), 64'(16'hDEAD));
               check_eq("to_en", 64'(en_a), 64'(0));
            end
         end
      end else begin
         for (int i = 0; i < lat; i++) begin
            tick();
            check_eq("hold", 64'({en_a, we_a, maddr_a, mdin_a, rdy_a}),
                     64'({1'b1, ewe, ea, ed, 2'b00}));
         end
         mrdy  = 1'b1;
         mdout = ewe ? 16'h5A5A : exp_rd;
         tick();
         mrdy  = 1'b0;
         mdout = 16'($urandom);
         check_eq("rdy", 64'(rdy_a), 64'(oh));
         check_eq("err", 64'(err_a), 64'(0));
         check_eq("en_drop", 64'(en_a), 64'(0));
         if (!ewe) check_eq("rdata", 64'(rdata_a), 64'(exp_rd));
         else mem_model[ea[7:0]] = ed;
         if (chk_b) check_eq("fp_rdy", 64'(rdy_b), 64'(2'b01));
      end
      tick();
      check_eq("pulse_end", 64'({rdy_a, err_a, en_a}), 64'(0));
   endtask

   initial begin
      n_pass = 0;
      n_checks = 0;
      clk = 1'b0;
      rst = 1'b0;
      req_en = 2'b00;
      req_we = 2'b00;
      addr0 = 16'd0; addr1 = 16'd0; wd0 = 16'd0; wd1 = 16'd0;
      mdout = 16'd0;
      mrdy = 1'b0;
      m_last = 1;
      for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);

      #1 rst = 1'b1;
      #1;
      check_eq("rst_mem", 64'({en_a, we_a, maddr_a, mdin_a}), 64'(0));
      check_eq("rst_req", 64'({rdy_a, err_a, rdata_a, gnt_a}), 64'(0));
      tick(); tick();
      rst = 1'b0;
      tick();
      check_eq("idle_en", 64'(en_a), 64'(0));

      // Single read by requester 0.
      mem_model[8'h00] = 16'h1234;
      req_en = 2'b01; req_we = 2'b00; addr0 = 16'h3000; wd0 = 16'h0000;
      do_access(2, 0, w);
      req_en[0] = 1'b0;

      // Write by requester 1.
      req_en = 2'b10; req_we = 2'b10; addr1 = 16'h4000; wd1 = 16'hBEEF;
      do_access(2, 0, w);
      req_en[1] = 1'b0;

      // Continuous contention: both instances see identical timing.
      req_en = 2'b11; req_we = 2'b00;
      addr0 = 16'h1010; addr1 = 16'h2020; wd0 = 16'h0101; wd1 = 16'h0202;
      for (int k = 0; k < 4; k++) begin
         do_access(1, 1, w);
         if (k > 0) check_eq("gap", 64'(last_gap), 64'(1));
      end
      req_en = 2'b00;
      tick();

      // Watchdog expiry, then memRDY on the terminal edge.
      req_en = 2'b01; req_we = 2'b00; addr0 = 16'h3005;
      do_access(-1, 0, w);
      req_en = 2'b00;
      tick();
      req_en = 2'b01; addr0 = 16'h3006;
      do_access(TO, 0, w);
      req_en = 2'b00;
      tick();

      // Reset in the middle of BUSY.
      req_en = 2'b01; req_we = 2'b00; addr0 = 16'h3333;
      for (int i = 0; i < 5 && !en_a; i++) tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_mem", 64'({en_a, we_a, maddr_a, mdin_a}), 64'(0));
      check_eq("mid_rst_req", 64'({rdy_a, err_a, rdata_a, gnt_a}), 64'(0));
      req_en = 2'b00;
      m_last = 1;
      tick(); tick();
      rst = 1'b0;
      mrdy = 1'b1;
      tick();
      mrdy = 1'b0;
      check_eq("stale_rdy0", 64'({rdy_a, en_a}), 64'(0));
      tick();
      check_eq("stale_rdy1", 64'({rdy_a, en_a}), 64'(0));
      req_en = 2'b11; req_we = 2'b00; addr0 = 16'h0044; addr1 = 16'h0055;
      do_access(0, 0, w);
      check_eq("post_rst_gnt", 64'(w), 64'(0));
      req_en = 2'b00;
      tick();

      // Randomized traffic against the transaction model.
      for (int k = 0; k < 40; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (!req_en[r] && $urandom_range(0, 2) != 0) set_req(r);
         end
         if (req_en == 2'b00) set_req(int'($urandom_range(0, 1)));
         do_access(int'($urandom_range(0, 5)), 0, w);
         req_en[w] = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
